// File: rtl/fetch_queue.sv
// IF-stage prefetch unit: owns the fetch PC and buffers {pc, instr} words in a DEPTH-entry FIFO.
// Optional statistics outputs are enabled with `define FETCH_STATS_EN.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'h0000_0001
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  output logic [31:0]              o_im_addr,
  input  logic [31:0]              i_im_data,
  input  logic                     i_im_valid,
  input  logic                     i_redirect_j,
  input  logic [31:0]              i_jump_target,
  input  logic                     i_redirect_b,
  input  logic [31:0]              i_branch_target,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [31:0]              o_out_instr,
  output logic [31:0]              o_out_pc,
  output logic [$clog2(DEPTH):0]   o_q_level
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]              o_stat_fetched,
  output logic [31:0]              o_stat_flushed,
  output logic [31:0]              o_stat_stall
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_STALL, S_REDIR} state_t;

  state_t          r_state, w_state_nx;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [PW:0]     r_level, w_level_nx;
  logic [31:0]     r_fetch_pc, r_hold_pc, r_hold_instr;
  logic [31:0]     r_mem_pc    [DEPTH];
  logic [31:0]     r_mem_instr [DEPTH];

  logic            w_redirect, w_fetching, w_full, w_pop, w_push;
  logic [31:0]     w_target;

  // Branch outranks jump: it belongs to the older instruction.
  assign w_redirect = i_redirect_b | i_redirect_j;
  assign w_target   = i_redirect_b ? i_branch_target : i_jump_target;
  assign w_fetching = (r_state == S_RUN) || (r_state == S_STALL);
  assign w_full     = (r_level == (PW+1)'(DEPTH));
  assign w_pop      = (r_level != '0) && i_out_ready;
  assign w_push     = i_im_valid && w_fetching && !w_redirect && (!w_full || w_pop);

  always_comb begin
    w_level_nx = r_level;
    if (w_redirect)
      w_level_nx = '0;
    else
      w_level_nx = r_level + (PW+1)'(w_push) - (PW+1)'(w_pop);
  end

  always_comb begin
    w_state_nx = r_state;
    if (w_redirect) begin
      w_state_nx = S_REDIR;
    end else begin
      case (r_state)
        S_BOOT:  w_state_nx = S_RUN;
        S_RUN:   if (w_push && (w_level_nx == (PW+1)'(DEPTH))) w_state_nx = S_STALL;
        S_STALL: if (w_pop) w_state_nx = S_RUN;
        S_REDIR: w_state_nx = S_RUN;
        default: w_state_nx = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_BOOT;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_fetch_pc   <= RESET_PC;
      r_hold_pc    <= '0;
      r_hold_instr <= '0;
    end else begin
      r_state <= w_state_nx;
      r_level <= w_level_nx;
      // Remember the head currently shown so the outputs can hold it once empty.
      if (r_level != '0) begin
        r_hold_pc    <= r_mem_pc[r_rd_ptr];
        r_hold_instr <= r_mem_instr[r_rd_ptr];
      end
      if (w_redirect) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_fetch_pc <= w_target;
      end else begin
        if (w_push) begin
          r_wr_ptr   <= r_wr_ptr + PW'(1);
          r_fetch_pc <= r_fetch_pc + PC_INC;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
      r_mem_instr[r_wr_ptr] <= i_im_data;
    end
  end

  assign o_im_addr   = r_fetch_pc;
  assign o_q_level   = r_level;
  assign o_out_valid = (r_level != '0);
  assign o_out_pc    = o_out_valid ? r_mem_pc[r_rd_ptr]    : r_hold_pc;
  assign o_out_instr = o_out_valid ? r_mem_instr[r_rd_ptr] : r_hold_instr;

`ifdef FETCH_STATS_EN
  logic [31:0] r_stat_fetched, r_stat_flushed, r_stat_stall;
  logic        w_killed;
  logic [32:0] w_flush_sum;

  // A word that would have been pushed but for the redirect counts as flushed too.
  assign w_killed    = i_im_valid && w_fetching && (!w_full || w_pop);
  assign w_flush_sum = {1'b0, r_stat_flushed} + 33'(r_level) + 33'(w_killed);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stat_fetched <= '0;
      r_stat_flushed <= '0;
      r_stat_stall   <= '0;
    end else begin
      if (w_push && (r_stat_fetched != 32'hFFFF_FFFF))
        r_stat_fetched <= r_stat_fetched + 32'd1;
      if (w_redirect)
        r_stat_flushed <= w_flush_sum[32] ? 32'hFFFF_FFFF : w_flush_sum[31:0];
      if ((r_state == S_STALL) && (r_stat_stall != 32'hFFFF_FFFF))
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign o_stat_fetched = r_stat_fetched;
  assign o_stat_flushed = r_stat_flushed;
  assign o_stat_stall   = r_stat_stall;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] o_im_addr;
  logic [31:0] i_im_data;
  logic        i_im_valid;
  logic        i_redirect_j;
  logic [31:0] i_jump_target;
  logic        i_redirect_b;
  logic [31:0] i_branch_target;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_out_instr;
  logic [31:0] o_out_pc;
  logic [2:0]  o_q_level;
`ifdef FETCH_STATS_EN
  logic [31:0] o_stat_fetched, o_stat_flushed, o_stat_stall;
`endif

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .o_im_addr(o_im_addr), .i_im_data(i_im_data),
    .i_im_valid(i_im_valid), .i_redirect_j(i_redirect_j), .i_jump_target(i_jump_target),
    .i_redirect_b(i_redirect_b), .i_branch_target(i_branch_target), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_out_instr(o_out_instr), .o_out_pc(o_out_pc),
    .o_q_level(o_q_level)
`ifdef FETCH_STATS_EN
    , .o_stat_fetched(o_stat_fetched), .o_stat_flushed(o_stat_flushed), .o_stat_stall(o_stat_stall)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue contents, fetch pointer, and whether this cycle may fetch.
  logic [31:0] m_qpc[$];
  logic [31:0] m_qin[$];
  logic [31:0] m_pc, m_last_pc, m_last_in;
  bit          m_blocked;
`ifdef FETCH_STATS_EN
  logic [31:0] m_fetched, m_flushed;
`endif

  function automatic logic [31:0] exp_pc();
    return (m_qpc.size() > 0) ? m_qpc[0] : m_last_pc;
  endfunction

  function automatic logic [31:0] exp_in();
    return (m_qin.size() > 0) ? m_qin[0] : m_last_in;
  endfunction

  task automatic model_reset();
    m_qpc.delete();
    m_qin.delete();
    m_pc      = 32'h0;
    m_last_pc = 32'h0;
    m_last_in = 32'h0;
    m_blocked = 1'b1;
`ifdef FETCH_STATS_EN
    m_fetched = 32'h0;
    m_flushed = 32'h0;
`endif
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    i_im_valid = 1'b0; i_out_ready = 1'b0; i_im_data = 32'h0;
    i_redirect_j = 1'b0; i_jump_target = 32'h0; i_redirect_b = 1'b0; i_branch_target = 32'h0;
    repeat (2) @(negedge i_clk);
    model_reset();
    i_reset = 1'b1;
  endtask

  // Drive one cycle (called at a negedge), advance the model, return at the next negedge.
  task automatic cyc(input bit v, input bit r, input bit rj, input logic [31:0] jt,
                     input bit rb, input logic [31:0] bt);
    int          sz;
    bit          pop, push;
    logic [63:0] fsum;
    i_im_valid = v; i_out_ready = r;
    i_redirect_j = rj; i_jump_target = jt; i_redirect_b = rb; i_branch_target = bt;
    i_im_data = m_pc + 32'h100;
    sz   = m_qpc.size();
    pop  = (sz > 0) && r;
    push = v && !m_blocked && ((sz < DEPTH) || pop);
    if (sz > 0) begin
      m_last_pc = m_qpc[0];
      m_last_in = m_qin[0];
    end
    if (rj || rb) begin
      fsum = 64'(m_flushed_get()) + 64'(sz) + 64'(push);
      m_flushed_set((fsum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : fsum[31:0]);
      m_qpc.delete();
      m_qin.delete();
      m_pc      = rb ? bt : jt;
      m_blocked = 1'b1;
    end else begin
      if (pop) begin
        void'(m_qpc.pop_front());
        void'(m_qin.pop_front());
      end
      if (push) begin
        m_qpc.push_back(m_pc);
        m_qin.push_back(m_pc + 32'h100);
        m_pc = m_pc + 32'h1;
`ifdef FETCH_STATS_EN
        m_fetched = m_fetched + 32'h1;
`endif
      end
      m_blocked = 1'b0;
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  function automatic logic [31:0] m_flushed_get();
`ifdef FETCH_STATS_EN
    return m_flushed;
`else
    return 32'h0;
`endif
  endfunction

  task automatic m_flushed_set(input logic [31:0] val);
`ifdef FETCH_STATS_EN
    m_flushed = val;
`else
    if (val === 32'hx) m_pc = m_pc;
`endif
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", o_out_valid); end
    n_vec++; if (o_q_level !== 3'd0) begin n_err++; $display("FAIL reset_level got=%0d exp=0", o_q_level); end
    n_vec++; if (o_im_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", o_im_addr); end
    n_vec++; if (o_out_pc !== 32'h0 || o_out_instr !== 32'h0) begin
      n_err++; $display("FAIL reset_out pc=%h instr=%h exp=0/0", o_out_pc, o_out_instr); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 0, 0, 0, 0);
      n_vec++;
      if (i == 0) begin
        if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL stream_boot valid=%b exp=0", o_out_valid); end
      end else if (o_out_valid !== 1'b1 || o_out_pc !== 32'(i - 1) || o_out_instr !== 32'(i - 1) + 32'h100) begin
        n_err++;
        $display("FAIL stream i=%0d valid=%b pc=%h instr=%h exp=1/%h/%h", i, o_out_valid, o_out_pc,
                 o_out_instr, 32'(i - 1), 32'(i - 1) + 32'h100);
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    repeat (8) cyc(1, 0, 0, 0, 0, 0);
    n_vec++;
    if (o_q_level !== 3'd4 || o_im_addr !== 32'd4 || o_out_pc !== 32'd0) begin
      n_err++; $display("FAIL full level=%0d addr=%h pc=%h exp=4/4/0", o_q_level, o_im_addr, o_out_pc);
    end
    cyc(1, 1, 0, 0, 0, 0);
    n_vec++;
    if (o_q_level !== 3'd4 || o_im_addr !== 32'd5 || o_out_pc !== 32'd1) begin
      n_err++; $display("FAIL full_pushpop level=%0d addr=%h pc=%h exp=4/5/1", o_q_level, o_im_addr, o_out_pc);
    end
    for (int j = 0; j < 3; j++) begin
      cyc(0, 1, 0, 0, 0, 0);
      n_vec++;
      if (o_out_pc !== 32'(2 + j) || o_out_instr !== 32'(2 + j) + 32'h100) begin
        n_err++; $display("FAIL full_drain j=%0d pc=%h instr=%h exp=%h", j, o_out_pc, o_out_instr, 32'(2 + j));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (4) cyc(1, 0, 0, 0, 0, 0);
    n_vec++; if (o_q_level !== 3'd3) begin n_err++; $display("FAIL redir_pre level=%0d exp=3", o_q_level); end
    cyc(1, 1, 1, 32'h20, 0, 0);
    n_vec++;
    if (o_q_level !== 3'd0 || o_out_valid !== 1'b0 || o_im_addr !== 32'h20 || o_out_pc !== 32'h0) begin
      n_err++; $display("FAIL redir_flush level=%0d valid=%b addr=%h pc=%h exp=0/0/20/0",
                        o_q_level, o_out_valid, o_im_addr, o_out_pc);
    end
`ifdef FETCH_STATS_EN
    n_vec++; if (o_stat_flushed !== 32'd4) begin n_err++; $display("FAIL redir_stat got=%0d exp=4", o_stat_flushed); end
`endif
    cyc(1, 1, 0, 0, 0, 0);
    n_vec++; if (o_out_valid !== 1'b0) begin n_err++; $display("FAIL redir_gap valid=%b exp=0", o_out_valid); end
    cyc(1, 1, 0, 0, 0, 0);
    n_vec++;
    if (o_out_valid !== 1'b1 || o_out_pc !== 32'h20 || o_out_instr !== 32'h120) begin
      n_err++; $display("FAIL redir_first valid=%b pc=%h instr=%h exp=1/20/120", o_out_valid, o_out_pc, o_out_instr);
    end
  endtask

  task automatic test_priority();
    bit seen = 1'b0;
    do_reset();
    repeat (3) cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'h80, 1, 32'h40);
    for (int k = 0; k < 6 && !seen; k++) begin
      cyc(1, 1, 0, 0, 0, 0);
      seen = o_out_valid;
    end
    n_vec++;
    if (!seen || o_out_pc !== 32'h40) begin
      n_err++; $display("FAIL priority seen=%b pc=%h exp=1/40", seen, o_out_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pcs [3];
    int idx = 0;
    exp_pcs[0] = 32'hFFFF_FFFE; exp_pcs[1] = 32'hFFFF_FFFF; exp_pcs[2] = 32'h0;
    do_reset();
    cyc(0, 1, 1, 32'hFFFF_FFFE, 0, 0);
    for (int k = 0; k < 10 && idx < 3; k++) begin
      cyc(1, 1, 0, 0, 0, 0);
      if (o_out_valid) begin
        n_vec++;
        if (o_out_pc !== exp_pcs[idx]) begin
          n_err++; $display("FAIL wrap idx=%0d pc=%h exp=%h", idx, o_out_pc, exp_pcs[idx]);
        end
        idx++;
      end
    end
    n_vec++; if (idx != 3) begin n_err++; $display("FAIL wrap_count got=%0d exp=3", idx); end
  endtask

  task automatic test_toggle();
    logic [31:0] nxt = 32'h0;
    int          got = 0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      cyc(k[0] == 1'b0, 1, 0, 0, 0, 0);
      if (o_out_valid) begin
        n_vec++;
        if (o_out_pc !== nxt || o_out_instr !== nxt + 32'h100) begin
          n_err++; $display("FAIL toggle k=%0d pc=%h instr=%h exp=%h", k, o_out_pc, o_out_instr, nxt);
        end
        nxt = nxt + 32'h1;
        got++;
      end
    end
    n_vec++; if (got < 6) begin n_err++; $display("FAIL toggle_count got=%0d exp>=6", got); end
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    #2 i_reset = 1'b0;
    #1;
    n_vec++;
    if (o_out_valid !== 1'b0 || o_q_level !== 3'd0 || o_im_addr !== 32'h0) begin
      n_err++; $display("FAIL midreset valid=%b level=%0d addr=%h exp=0/0/0", o_out_valid, o_q_level, o_im_addr);
    end
    @(negedge i_clk);
    model_reset();
    i_reset = 1'b1;
  endtask

  task automatic test_random();
    bit v, r, rj, rb;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) != 0);
      rj = ($urandom_range(0, 19) == 0);
      rb = ($urandom_range(0, 24) == 0);
      cyc(v, r, rj, $urandom, rb, $urandom);
      n_vec++;
      if (o_out_valid !== (m_qpc.size() > 0) || o_q_level !== 3'(m_qpc.size()) || o_im_addr !== m_pc ||
          o_out_pc !== exp_pc() || o_out_instr !== exp_in()) begin
        n_err++;
        $display("FAIL random k=%0d valid=%b/%b level=%0d/%0d addr=%h/%h pc=%h/%h instr=%h/%h", k,
                 o_out_valid, m_qpc.size() > 0, o_q_level, m_qpc.size(), o_im_addr, m_pc,
                 o_out_pc, exp_pc(), o_out_instr, exp_in());
      end
    end
`ifdef FETCH_STATS_EN
    n_vec++;
    if (o_stat_fetched !== m_fetched || o_stat_flushed !== m_flushed) begin
      n_err++; $display("FAIL random_stats fetched=%0d/%0d flushed=%0d/%0d",
                        o_stat_fetched, m_fetched, o_stat_flushed, m_flushed);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_priority();
    test_wrap();
    test_toggle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
